// File: rtl/cam_search_ctrl.sv
// 32-entry content-addressable memory with a four-state search controller.
// A search registers per-entry matches, priority-encodes the lowest hit and holds it until consumed.
module cam_search_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write_valid,
  input  logic [4:0]           write_index,
  input  logic [WIDTH-1:0]     write_data,
  input  logic                 invalidate_valid,
  input  logic [4:0]           invalidate_index,
  input  logic                 search_valid,
  input  logic [WIDTH-1:0]     search_data,
  output logic                 search_ready,
  output logic [32*WIDTH-1:0]  entry_data,
  output logic [31:0]          entry_valid,
  output logic                 result_valid,
  output logic                 result_hit,
  output logic [4:0]           result_index,
  input  logic                 result_ready
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPARE = 2'd1;
  localparam logic [1:0] ENCODE  = 2'd2;
  localparam logic [1:0] RESULT  = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] entryMem [32];
  logic [31:0]      entryValid;
  logic [WIDTH-1:0] keyReg;
  logic [31:0]      matchReg;
  logic [31:0]      matchNext;
  logic [4:0]       encIndex;
  logic             resultHit;
  logic [4:0]       resultIndex;

  // NOTE: the entry array is reset explicitly because entry_data feeds a
  // downstream mux directly and must read as zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        entryMem[i] <= '0;
      end
      entryValid <= '0;
    end else begin
      if (write_valid) begin
        entryMem[write_index]   <= write_data;
        entryValid[write_index] <= 1'b1;
      end
      // NOTE: the invalidate is written after the write so that, for the same
      // index, the later non-blocking assignment wins and the entry ends invalid.
      if (invalidate_valid) begin
        entryValid[invalidate_index] <= 1'b0;
      end
    end
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    matchNext = '0;
    for (int i = 0; i < 32; i++) begin
      matchNext[i] = entryValid[i] && (entryMem[i] == keyReg);
    end
  end

  // Scanning downward leaves the lowest matching index as the final assignment.
  always_comb begin
    encIndex = '0;
    for (int i = 31; i >= 0; i--) begin
      if (matchReg[i]) begin
        encIndex = 5'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      keyReg      <= '0;
      matchReg    <= '0;
      resultHit   <= 1'b0;
      resultIndex <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (search_valid) begin
            keyReg <= search_data;
            state  <= COMPARE;
          end
        end
        COMPARE: begin
          matchReg <= matchNext;
          state    <= ENCODE;
        end
        ENCODE: begin
          resultHit   <= |matchReg;
          resultIndex <= encIndex;
          state       <= RESULT;
        end
        RESULT: begin
          if (result_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < 32; g++) begin : g_entry
    assign entry_data[g*WIDTH +: WIDTH] = entryMem[g];
  end

  assign entry_valid  = entryValid;
  assign search_ready = (state == IDLE) && !reset;
  assign result_valid = (state == RESULT) && !reset;
  assign result_hit   = resultHit;
  assign result_index = resultIndex;

endmodule
